avg_feed_arbiter: RTL and testbench
===================================

AVG_FEED_ARBITER -- requirements
Module: avg_feed_arbiter

Interface
REQ-001 Parameter SHALL be NUM_REQ, default 4, meaning the number of sample requesters (2..8).
REQ-002 Parameter SHALL be WIN_LEN_LOG2, default 5, meaning log2 of the averaging window length (32 samples).
REQ-003 Port SHALL be clk  input  1  single clock for all logic.
REQ-004 Port SHALL be reset  input  1  asynchronous, active-high reset.
REQ-005 Port SHALL be enable  input  1  gate for slot generation.
REQ-006 Port SHALL be pace_div  input  8  slot period minus one, in clk cycles.
REQ-007 Port SHALL be req_valid  input  NUM_REQ  per-requester sample available.
REQ-008 Port SHALL be req_data  input  8*NUM_REQ  per-requester sample; requester i occupies bits [8i+7:8i].
REQ-009 Port SHALL be req_ready  output  NUM_REQ  per-requester accept strobe.
REQ-010 Port SHALL be filt_in  output  8  sample to the averaging filter input.
REQ-011 Port SHALL be filt_in_latch  output  1  one-cycle write strobe to the averaging filter.
REQ-012 Port SHALL be grant_id  output  $clog2(NUM_REQ)  index of the most recently granted requester.
REQ-013 Port SHALL be sample_count  output  WIN_LEN_LOG2  samples latched in the current window.
REQ-014 Port SHALL be window_done  output  1  one-cycle pulse when a window's final sample is latched.

Function
REQ-015 Pace counter SHALL count 0..pace_div and reload to 0; a slot SHALL be the cycle with counter == pace_div and enable high.
REQ-016 pace_div == 0 SHALL give a slot every cycle while enable is high.
REQ-017 pace_div SHALL be sampled at each reload; a change mid-period SHALL only take effect after the current period ends.
REQ-018 While enable is low, the pace counter SHALL hold at 0 and no slot, req_ready or filt_in_latch SHALL occur.
REQ-019 In a slot cycle, the arbiter SHALL grant the first valid requester in round-robin order, starting at index last_grant+1 modulo NUM_REQ.
REQ-020 req_ready SHALL be combinational and one-hot: req_ready[i] = slot AND grant_i; it SHALL be all zero in non-slot cycles.
REQ-021 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; there SHALL be at most one transfer per cycle.
REQ-022 A slot with no valid requester SHALL produce no transfer and SHALL leave last_grant unchanged.
REQ-023 On a transfer, filt_in SHALL be registered from the granted req_data lane and filt_in_latch SHALL be high the next cycle (latency 1), then low.
REQ-024 filt_in SHALL hold its last value when no transfer occurs.
REQ-025 On a transfer, grant_id and last_grant SHALL update to the granted index, registered with the same timing as filt_in.
REQ-026 sample_count SHALL increment on each filt_in_latch cycle and wrap from 2^WIN_LEN_LOG2-1 to 0.
REQ-027 window_done SHALL pulse in the same cycle sample_count wraps to 0.
REQ-028 A requester that deasserts req_valid in a slot cycle SHALL not be granted; the grant SHALL pass to the next valid requester in round-robin order in that same cycle.

Reset
REQ-029 Reset SHALL force these values immediately, independent of clk: filt_in=0, filt_in_latch=0, window_done=0, sample_count=0, grant_id=NUM_REQ-1, last_grant=NUM_REQ-1, pace counter=0.
REQ-030 After reset, requester 0 SHALL have highest priority at the first slot.
REQ-031 Reset asserted mid-window SHALL discard the partial sample count; no window_done SHALL be emitted for the discarded window.
REQ-032 req_ready SHALL be 0 while reset is high.

Verification
REQ-033 Scenario: reset, then pace_div=3 with enable held high -> slots at cycles 3, 7, 11, ...; filt_in_latch one cycle after each slot that has a requester valid.
REQ-034 Scenario: all 4 requesters valid, pace_div=0 -> grants 0,1,2,3,0,...; filt_in equals the matching lane each cycle; exactly one req_ready bit high per cycle.
REQ-035 Scenario: only requester 2 valid, data=0x5A -> every slot grants 2; filt_in=0x5A; grant_id=2.
REQ-036 Scenario: 32 transfers at pace_div=0 -> sample_count runs 1..31, then 0 with window_done=1 on the 32nd filt_in_latch cycle; window_done=0 otherwise.
REQ-037 Scenario: pace_div changed from 7 to 1 at counter value 2 -> the current period still ends at count 7; later slots are every 2 cycles.
REQ-038 Scenario: reset pulsed when sample_count=17 -> all outputs at reset values immediately; no window_done; the next grant goes to requester 0.

Source files
------------

// File: rtl/avg_feed_arbiter.sv
// Paced round-robin arbiter. Each pace slot moves one requester sample into an
// averaging filter and counts the samples of the current window.
module avg_feed_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int WIN_LEN_LOG2 = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [7:0]                 pace_div,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 filt_in,
  output logic                       filt_in_latch,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [WIN_LEN_LOG2-1:0]    sample_count,
  output logic                       window_done
);
  localparam int GW = $clog2(NUM_REQ);

  logic [7:0]              pace_cnt_q, pace_cnt_d;
  logic [7:0]              pace_lim_q, pace_lim_d;
  logic [7:0]              pace_limit_s;
  logic                    slot_s;
  logic                    grant_found_s;
  logic                    xfer_s;
  logic [GW-1:0]           grant_idx_s;
  logic [7:0]              filt_in_q, filt_in_d;
  logic                    filt_in_latch_q, filt_in_latch_d;
  logic [GW-1:0]           grant_id_q, grant_id_d;
  logic [WIN_LEN_LOG2-1:0] sample_count_q, sample_count_d;
  logic                    window_done_q, window_done_d;

  // The live pace_div is used at count 0 and captured, so a period keeps its length.
  always_comb begin
    pace_limit_s  = (pace_cnt_q == 8'd0) ? pace_div : pace_lim_q;
    slot_s        = enable && !reset && (pace_cnt_q == pace_limit_s);
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_found_s && req_valid[j] &&
            (j == ((int'(grant_id_q) + k) % NUM_REQ))) begin
          grant_found_s = 1'b1;
          grant_idx_s   = GW'(j);
        end
      end
    end
    xfer_s    = slot_s && grant_found_s;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer_s && (grant_idx_s == GW'(i));
    end
  end

  always_comb begin
    if (!enable) begin
      pace_cnt_d = 8'd0;
    end else if (pace_cnt_q == pace_limit_s) begin
      pace_cnt_d = 8'd0;
    end else begin
      pace_cnt_d = pace_cnt_q + 8'd1;
    end
    pace_lim_d      = (pace_cnt_q == 8'd0) ? pace_div : pace_lim_q;
    filt_in_latch_d = xfer_s;
    if (xfer_s) begin
      filt_in_d      = req_data[int'(grant_idx_s)*8 +: 8];
      grant_id_d     = grant_idx_s;
      sample_count_d = sample_count_q + WIN_LEN_LOG2'(1);
      window_done_d  = (sample_count_q == {WIN_LEN_LOG2{1'b1}});
    end else begin
      filt_in_d      = filt_in_q;
      grant_id_d     = grant_id_q;
      sample_count_d = sample_count_q;
      window_done_d  = 1'b0;
    end
  end

  // grant_id_q doubles as the round-robin pointer (last grant).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pace_cnt_q      <= 8'd0;
      pace_lim_q      <= 8'd0;
      filt_in_q       <= 8'd0;
      filt_in_latch_q <= 1'b0;
      grant_id_q      <= GW'(NUM_REQ - 1);
      sample_count_q  <= '0;
      window_done_q   <= 1'b0;
    end else begin
      pace_cnt_q      <= pace_cnt_d;
      pace_lim_q      <= pace_lim_d;
      filt_in_q       <= filt_in_d;
      filt_in_latch_q <= filt_in_latch_d;
      grant_id_q      <= grant_id_d;
      sample_count_q  <= sample_count_d;
      window_done_q   <= window_done_d;
    end
  end

  assign filt_in       = filt_in_q;
  assign filt_in_latch = filt_in_latch_q;
  assign grant_id      = grant_id_q;
  assign sample_count  = sample_count_q;
  assign window_done   = window_done_q;
endmodule

// File: tb/tb_avg_feed_arbiter.sv
// Scoreboard bench for avg_feed_arbiter: a cycle model predicts req_ready and
// queues the expected filter write, popped when filt_in_latch should appear.
module tb_avg_feed_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  pace_div = 8'd0;
  logic [3:0]  req_valid = 4'd0;
  logic [31:0] req_data = 32'd0;
  logic [3:0]  req_ready;
  logic [7:0]  filt_in;
  logic        filt_in_latch;
  logic [1:0]  grant_id;
  logic [4:0]  sample_count;
  logic        window_done;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    logic [4:0] cnt;
    logic       wd;
  } exp_t;

  exp_t       sb_q[$];
  int         vectors = 0;
  int         errors = 0;
  int         m_cnt, m_div, m_last, m_count;
  logic [7:0] m_filt;
  logic       exp_latch;

  avg_feed_arbiter #(.NUM_REQ(4), .WIN_LEN_LOG2(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pace_div(pace_div),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .filt_in(filt_in), .filt_in_latch(filt_in_latch), .grant_id(grant_id),
    .sample_count(sample_count), .window_done(window_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_clear();
    m_cnt = 0; m_div = 0; m_last = 3; m_count = 0;
    m_filt = 8'd0; exp_latch = 1'b0;
    sb_q.delete();
  endtask

  // One clock cycle: predict and check req_ready, then check the registered outputs.
  task automatic tick();
    int limit;
    int g;
    logic [1:0] idx;
    logic [3:0] exp_ready;
    exp_t e;
    #1;
    limit = (m_cnt == 0) ? int'(pace_div) : m_div;
    g = -1;
    if (enable && (m_cnt == limit)) begin
      for (int k = 1; k <= 4; k++) begin
        idx = 2'((m_last + k) % 4);
        if (g < 0 && req_valid[idx]) g = int'(idx);
      end
    end
    exp_ready = 4'd0;
    if (g >= 0) exp_ready[g] = 1'b1;
    vectors++;
    if (req_ready !== exp_ready) begin
      errors++;
      $display("FAIL req_ready: got %b want %b", req_ready, exp_ready);
    end
    if (m_cnt == 0) m_div = int'(pace_div);
    if (!enable || (m_cnt == limit)) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    if (g >= 0) begin
      m_count = (m_count + 1) % 32;
      e.data = req_data[g*8 +: 8];
      e.id = 2'(g);
      e.cnt = 5'(m_count);
      e.wd = (m_count == 0);
      sb_q.push_back(e);
      m_last = g;
      m_filt = e.data;
      exp_latch = 1'b1;
    end else begin
      exp_latch = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (filt_in_latch !== exp_latch) begin
      errors++;
      $display("FAIL filt_in_latch: got %b want %b", filt_in_latch, exp_latch);
    end
    if (exp_latch) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got empty queue want one entry");
      end else begin
        e = sb_q.pop_front();
        vectors++;
        if ({filt_in, grant_id, sample_count, window_done} !== {e.data, e.id, e.cnt, e.wd}) begin
          errors++;
          $display("FAIL transfer: got data=%h id=%0d cnt=%0d wd=%b want data=%h id=%0d cnt=%0d wd=%b",
                   filt_in, grant_id, sample_count, window_done, e.data, e.id, e.cnt, e.wd);
        end
      end
    end else begin
      vectors++;
      if ({filt_in, grant_id, sample_count, window_done} !== {m_filt, 2'(m_last), 5'(m_count), 1'b0}) begin
        errors++;
        $display("FAIL idle hold: got data=%h id=%0d cnt=%0d wd=%b want data=%h id=%0d cnt=%0d wd=0",
                 filt_in, grant_id, sample_count, window_done, m_filt, m_last, m_count);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    vectors++;
    if ({filt_in, filt_in_latch, window_done, sample_count, grant_id, req_ready} !==
        {8'h00, 1'b0, 1'b0, 5'd0, 2'd3, 4'd0}) begin
      errors++;
      $display("FAIL reset values: got data=%h latch=%b wd=%b cnt=%0d id=%0d ready=%b want 00 0 0 0 3 0000",
               filt_in, filt_in_latch, window_done, sample_count, grant_id, req_ready);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_pace();
    do_reset();
    pace_div = 8'd3; enable = 1'b1; req_valid = 4'b0001; req_data = 32'h44332211;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (filt_in_latch !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL pace slot %0d: got latch=%b want %b", i, filt_in_latch, (i % 4) == 3);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    pace_div = 8'd0; enable = 1'b1; req_valid = 4'b1111; req_data = 32'h44332211;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (grant_id !== 2'(i % 4) || filt_in !== 8'(8'h11 * (i % 4 + 1))) begin
        errors++;
        $display("FAIL round robin %0d: got id=%0d data=%h want id=%0d data=%h",
                 i, grant_id, filt_in, i % 4, 8'(8'h11 * (i % 4 + 1)));
      end
      vectors++;
      if ($countones(req_ready) != 1) begin
        errors++;
        $display("FAIL one-hot ready: got %b want exactly one bit", req_ready);
      end
    end
  endtask

  task automatic test_single();
    int latches = 0;
    pace_div = 8'd1; req_valid = 4'b0100; req_data = 32'h005A0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (filt_in_latch) latches++;
    end
    vectors++;
    if (grant_id !== 2'd2 || filt_in !== 8'h5A || latches != 4) begin
      errors++;
      $display("FAIL single requester: got id=%0d data=%h latches=%0d want id=2 data=5a latches=4",
               grant_id, filt_in, latches);
    end
  endtask

  task automatic test_window();
    do_reset();
    pace_div = 8'd0; enable = 1'b1; req_valid = 4'b1111; req_data = 32'hA1B2C3D4;
    for (int i = 0; i < 32; i++) begin
      tick();
      vectors++;
      if (sample_count !== 5'((i + 1) % 32) || window_done !== (i == 31)) begin
        errors++;
        $display("FAIL window %0d: got cnt=%0d wd=%b want cnt=%0d wd=%b",
                 i, sample_count, window_done, (i + 1) % 32, i == 31);
      end
    end
  endtask

  task automatic test_pace_change();
    do_reset();
    enable = 1'b1; pace_div = 8'd7; req_valid = 4'b0001; req_data = 32'h000000C7;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) pace_div = 8'd1;
      tick();
      vectors++;
      if (filt_in_latch !== (i == 7 || i == 9 || i == 11 || i == 13)) begin
        errors++;
        $display("FAIL pace change %0d: got latch=%b want %b",
                 i, filt_in_latch, (i == 7 || i == 9 || i == 11 || i == 13));
      end
    end
  endtask

  task automatic test_enable_low();
    enable = 1'b0; pace_div = 8'd0; req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (filt_in_latch !== 1'b0 || req_ready !== 4'd0) begin
        errors++;
        $display("FAIL enable low: got latch=%b ready=%b want 0 0000", filt_in_latch, req_ready);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_valid_drop();
    do_reset();
    pace_div = 8'd0; enable = 1'b1; req_valid = 4'b1111; req_data = 32'h44332211;
    tick();
    req_valid = 4'b1101;
    tick();
    vectors++;
    if (grant_id !== 2'd2) begin
      errors++;
      $display("FAIL valid drop: got id=%0d want 2", grant_id);
    end
    req_valid = 4'b0000;
    tick();
    vectors++;
    if (filt_in_latch !== 1'b0 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL empty slot: got latch=%b id=%0d want 0 2", filt_in_latch, grant_id);
    end
    req_valid = 4'b1111;
    tick();
    vectors++;
    if (grant_id !== 2'd3 || filt_in !== 8'h44) begin
      errors++;
      $display("FAIL after empty slot: got id=%0d data=%h want 3 44", grant_id, filt_in);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pace_div = 8'd0; enable = 1'b1; req_valid = 4'b1111; req_data = 32'h99887766;
    for (int i = 0; i < 17; i++) tick();
    vectors++;
    if (sample_count !== 5'd17) begin
      errors++;
      $display("FAIL pre-reset count: got %0d want 17", sample_count);
    end
    test_reset();
    tick();
    vectors++;
    if (grant_id !== 2'd0 || sample_count !== 5'd1 || filt_in !== 8'h66) begin
      errors++;
      $display("FAIL post-reset grant: got id=%0d cnt=%0d data=%h want 0 1 66",
               grant_id, sample_count, filt_in);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      vectors++;
      if (window_done !== 1'b0) begin
        errors++;
        $display("FAIL discarded window: got wd=%b want 0 at step %0d", window_done, i);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_pace();
    test_round_robin();
    test_single();
    test_window();
    test_pace_change();
    test_enable_low();
    test_valid_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
